// File: rtl/id_ex_decode_stage.sv
// Decode stage and ID/EX pipeline register for the 5-stage RV64 pipeline.
// Decodes control, builds immediates, bypasses write-back data and inserts load-use bubbles.
module id_ex_decode_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,

    output logic [4:0]        rf_rs1,
    output logic [4:0]        rf_rs2,
    input  logic [XLEN-1:0]   rf_data1,
    input  logic [XLEN-1:0]   rf_data2,

    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,

    input  logic              flush,
    output logic              stall_out,

    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_data1,
    output logic [XLEN-1:0]   ex_data2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic [1:0]        ex_alu_op,
    output logic [3:0]        ex_funct,

    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      funct;

    logic            dec_alu_src;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_reg_write;
    logic            dec_mem_to_reg;
    logic            dec_branch;
    logic [1:0]      dec_alu_op;
    logic [XLEN-1:0] dec_imm;
    logic            uses_rs1;
    logic            uses_rs2;

    logic [XLEN-1:0] byp_data1;
    logic [XLEN-1:0] byp_data2;

    logic            hazard;
    logic            stall_c;
    logic            load_dec;

    assign opcode = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];
    assign funct  = {if_instr[30], if_instr[14:12]};

    assign rf_rs1 = rs1;
    assign rf_rs2 = rs2;

    // Control decode and register-usage flags by opcode.
    always_comb begin
        dec_alu_src    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_alu_op     = ALU_ADD;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        case (opcode)
            OP_R: begin
                dec_reg_write = 1'b1;
                dec_alu_op    = ALU_R;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_I: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = ALU_I;
                uses_rs1      = 1'b1;
            end
            OP_LOAD: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_op     = ALU_ADD;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_alu_op    = ALU_ADD;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec_branch = 1'b1;
                dec_alu_op = ALU_BR;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Sign-extended immediate generation.
    always_comb begin
        dec_imm = '0;
        case (opcode)
            OP_I, OP_LOAD:
                dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            OP_STORE:
                dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH:
                dec_imm = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                           if_instr[30:25], if_instr[11:8], 1'b0};
            default:
                dec_imm = '0;
        endcase
    end

    // The register file writes on the edge, so same-cycle write-back must be forwarded here.
    always_comb begin
        if (rs1 == 5'd0) begin
            byp_data1 = '0;
        end else if (wb_regwrite && (wb_rd == rs1)) begin
            byp_data1 = wb_data;
        end else begin
            byp_data1 = rf_data1;
        end
    end

    always_comb begin
        if (rs2 == 5'd0) begin
            byp_data2 = '0;
        end else if (wb_regwrite && (wb_rd == rs2)) begin
            byp_data2 = wb_data;
        end else begin
            byp_data2 = rf_data2;
        end
    end

    // Load in EX whose destination is read by the instruction now being decoded.
    assign hazard = if_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((uses_rs1 & (ex_rd == rs1)) | (uses_rs2 & (ex_rd == rs2)));

    assign stall_c   = hazard & ~flush & ~reset;
    assign stall_out = stall_c;
    assign load_dec  = if_valid & ~flush & ~hazard;

    // ID/EX register: decoded instruction or bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_data1      <= '0;
            ex_data2      <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_op     <= '0;
            ex_funct      <= '0;
        end else if (load_dec) begin
            ex_valid      <= 1'b1;
            ex_pc         <= if_pc;
            ex_data1      <= byp_data1;
            ex_data2      <= byp_data2;
            ex_imm        <= dec_imm;
            ex_rs1        <= rs1;
            ex_rs2        <= rs2;
            ex_rd         <= rd;
            ex_alu_src    <= dec_alu_src;
            ex_mem_read   <= dec_mem_read;
            ex_mem_write  <= dec_mem_write;
            ex_reg_write  <= dec_reg_write;
            ex_mem_to_reg <= dec_mem_to_reg;
            ex_branch     <= dec_branch;
            ex_alu_op     <= dec_alu_op;
            ex_funct      <= funct;
        end else begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_data1      <= '0;
            ex_data2      <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_op     <= '0;
            ex_funct      <= '0;
        end
    end

    // Saturating count of hazard stall cycles; flush suppresses the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_c && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/id_ex_decode_stage.md
# id_ex_decode_stage

Decode stage and ID/EX pipeline register of the 5-stage RV64 pipeline. It sits between the IF/ID register and the execute stage. It drives the register-file read addresses and captures the read data, with a write-back bypass. It also decodes control signals, generates immediates, detects load-use hazards and inserts bubbles on stall or flush. A saturating stall counter is included for performance analysis.

## Interface
Parameters:
- XLEN, 64, datapath width.
- CNT_W, 32, stall-counter width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_instr  in  32  instruction from IF/ID.
- if_pc  in  XLEN  PC of if_instr.
- rf_rs1, rf_rs2  out  5  register-file read addresses; combinational from if_instr[19:15] and [24:20].
- rf_data1, rf_data2  in  XLEN  register-file read data, combinational.
- wb_regwrite  in  1  write-back stage is writing this cycle.
- wb_rd  in  5  write-back destination register.
- wb_data  in  XLEN  write-back data.
- flush  in  1  taken branch resolved in EX; kill the decoding instruction.
- stall_out  out  1  load-use hazard; IF and IF/ID must hold.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc, ex_data1, ex_data2, ex_imm  out  XLEN  registered PC, operands and immediate.
- ex_rs1, ex_rs2, ex_rd  out  5  registered register indices.
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1 each  registered control signals.
- ex_alu_op  out  2  ALU class: 00 add, 01 branch compare, 10 R-type, 11 I-type ALU.
- ex_funct  out  4  {instr[30], instr[14:12]}.
- stall_count  out  CNT_W  number of hazard stall cycles.

## Operation
Decode, by opcode:
- R-type 0110011: reg_write=1, alu_op=10.
- I-type ALU 0010011: alu_src=1, reg_write=1, alu_op=11.
- Load 0000011: alu_src=1, mem_read=1, reg_write=1, mem_to_reg=1, alu_op=00.
- Store 0100011: alu_src=1, mem_write=1, alu_op=00.
- Branch 1100011: branch=1, alu_op=01.
- Any other opcode: all control signals 0, ex_valid=1 (executes as a NOP).
- Only controls are zeroed for other opcodes. ex_pc, ex_data1/2, ex_rs1/2, ex_rd, ex_funct and ex_imm still load normally from if_instr.

Immediates, sign-extended to XLEN:
- I-type and load: instr[31:20].
- Store: {instr[31:25], instr[11:7]}.
- Branch: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- R-type and other opcodes: 0.

Operand bypass (the register file writes on the clock edge, so a same-cycle read returns the old value):
- data1 = 0 if rs1==0.
- Otherwise data1 = wb_data if wb_regwrite and wb_rd==rs1.
- Otherwise data1 = rf_data1.
- data2 uses the same rule with rs2.

Register usage:
- uses_rs1: R-type, I-type ALU, load, store, branch.
- uses_rs2: R-type, store, branch.

Load-use hazard:
- hazard = if_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)).
- stall_out = hazard & !flush.

Per-edge priority:
1. reset: all outputs 0.
2. flush: bubble loaded.
3. hazard: bubble loaded, stall_count += 1.
4. if_valid: decoded instruction loaded.
5. else: bubble loaded.

Bubble: ex_valid=0, all control signals 0, all data and index fields 0.

stall_count saturates at all-ones.

## Timing
- Reset: every registered output is 0, including stall_count. stall_out is 0 during reset.
- Latency: an instruction presented in cycle N appears on the ex_* outputs after edge N+1.
- rf_rs1/rf_rs2, the bypass and stall_out are combinational within the cycle.
- Stall: IF/ID holds its content. The next cycle re-decodes the same instruction, by which time the load has moved to MEM and the hazard clears. Exactly one bubble is inserted per load-use pair.
- Flush and hazard in the same cycle: flush wins, stall_out=0, stall_count is unchanged.
- Reset asserted mid-stall: outputs clear at the next edge and stall_out drops in the same cycle.
- Back-to-back valid instructions with no hazard: one issue per cycle and no bubbles.

## Test plan
- Reset: hold reset 2 cycles with if_valid=1 -> all ex_* = 0, stall_count = 0, stall_out = 0.
- Decode and immediates:
  - addi x5,x1,-3 -> ex_imm=0xFFFF_FFFF_FFFF_FFFD, alu_src=1, reg_write=1, alu_op=11, ex_rd=5.
  - sd x2,16(x3) -> ex_imm=16, mem_write=1.
  - beq offset -8 -> ex_imm=-8, branch=1.
- WB bypass: rf_data1=0x11, wb_regwrite=1, wb_rd=rs1=7, wb_data=0x99 -> ex_data1=0x99. Same case with rs1=0 -> ex_data1=0.
- Load-use: ld x4,0(x1) followed by add x6,x4,x2 -> stall_out=1 for one cycle, one bubble (ex_valid=0), stall_count=1, then add issues. The same sequence with rd=x0 -> no stall.
- Flush priority: flush=1 together with a load-use hazard -> stall_out=0, bubble loaded, stall_count unchanged.
- Unknown opcode 0x7F -> ex_valid=1, all control signals 0, ex_imm=0.
